// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, FSM state and flag bundle for the registered ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic lt;
        logic gt;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [3:0]       aluop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             lt;
    logic             gt;
    logic             carry;
    logic             ovf;

    // Producer/consumer side driving operands and taking results.
    modport master (
        output in_valid, data1, data2, aluop, out_ready,
        input  in_ready, out_valid, result, zero, lt, gt, carry, ovf
    );

    // ALU side.
    modport slave (
        input  in_valid, data1, data2, aluop, out_ready,
        output in_ready, out_valid, result, zero, lt, gt, carry, ovf
    );
endinterface

// File: rtl/alu_pipe_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done and product are combinational during the final step so the caller can
// register the product on the same edge the last step completes.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] step;

    // One step: conditionally add the multiplicand into the upper half, then shift right.
    always_comb begin
        upper   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        step    = {upper, acc_q[WIDTH-1:1]};
        done    = busy_q && (cnt_q == CW'(WIDTH - 1));
        product = step;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            a_d    = a;
            acc_d  = {{WIDTH{1'b0}}, b};
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Step counter and accumulator; reset drops any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            acc_q  <= acc_d;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops load the
// output register on the accept edge; MUL runs through alu_mul_seq.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_t         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    alu_flags_t         flags_q, flags_d;
    logic               cmp_lt_q, cmp_lt_d;
    logic               cmp_gt_q, cmp_gt_d;

    logic               in_ready;
    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   alu_res;
    alu_flags_t         alu_flags;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic signed [WIDTH:0] cmp_a;
    logic signed [WIDTH:0] cmp_b;
    logic [SHW-1:0]     shamt;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.data1),
        .b       (bus.data2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; compares extend by one bit so one signed compare covers both modes.
    always_comb begin
        add_full  = {1'b0, bus.data1} + {1'b0, bus.data2};
        sub_full  = {1'b0, bus.data1} - {1'b0, bus.data2};
        shamt     = bus.data2[SHW-1:0];
        cmp_a     = {(SIGNED_CMP ? bus.data1[WIDTH-1] : 1'b0), bus.data1};
        cmp_b     = {(SIGNED_CMP ? bus.data2[WIDTH-1] : 1'b0), bus.data2};
        alu_flags = '0;
        alu_flags.lt = (cmp_a < cmp_b);
        alu_flags.gt = (cmp_a > cmp_b);
        case (bus.aluop)
            ALU_SUB: begin
                alu_res         = sub_full[WIDTH-1:0];
                alu_flags.carry = ~sub_full[WIDTH];
                alu_flags.ovf   = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                                  (sub_full[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            ALU_AND: alu_res = bus.data1 & bus.data2;
            ALU_OR:  alu_res = bus.data1 | bus.data2;
            ALU_XOR: alu_res = bus.data1 ^ bus.data2;
            ALU_SLL: alu_res = bus.data1 << shamt;
            ALU_SRL: alu_res = bus.data1 >> shamt;
            ALU_SRA: alu_res = $signed(bus.data1) >>> shamt;
            default: begin
                alu_res         = add_full[WIDTH-1:0];
                alu_flags.carry = add_full[WIDTH];
                alu_flags.ovf   = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                                  (add_full[WIDTH-1] != bus.data1[WIDTH-1]);
            end
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    // Handshake, FSM next state and output register next values.
    always_comb begin
        in_ready    = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready;
        is_mul      = (bus.aluop == ALU_MUL);
        mul_start   = accept && is_mul;
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        cmp_lt_d    = cmp_lt_q;
        cmp_gt_d    = cmp_gt_q;
        if (accept && !is_mul) begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
        end
        if (mul_start) begin
            state_d  = MUL;
            cmp_lt_d = alu_flags.lt;
            cmp_gt_d = alu_flags.gt;
        end
        if ((state_q == MUL) && mul_done) begin
            state_d       = IDLE;
            result_d      = mul_product[WIDTH-1:0];
            flags_d.zero  = (mul_product[WIDTH-1:0] == '0);
            flags_d.lt    = cmp_lt_q;
            flags_d.gt    = cmp_gt_q;
            flags_d.carry = 1'b0;
            flags_d.ovf   = (mul_product[2*WIDTH-1:WIDTH] != '0);
            out_valid_d   = 1'b1;
        end
    end

    // FSM state and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            cmp_lt_q    <= 1'b0;
            cmp_gt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            cmp_lt_q    <= cmp_lt_d;
            cmp_gt_q    <= cmp_gt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = flags_q.zero;
    assign bus.lt        = flags_q.lt;
    assign bus.gt        = flags_q.gt;
    assign bus.carry     = flags_q.carry;
    assign bus.ovf       = flags_q.ovf;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16, unsigned compares.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ov_seen;

    alu_pipe_if #(.WIDTH(16)) bus ();

    alu_pipe #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Flag vector ordering: {zero, lt, gt, carry, ovf}
    logic [4:0] flg;
    assign flg = {bus.zero, bus.lt, bus.gt, bus.carry, bus.ovf};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for one cycle (call right after an edge); checks outputs after the accept edge.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_res, input logic [4:0] exp_flg);
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.data1    = a;
        bus.data2    = b;
        #1;
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, "_ov"},  32'(bus.out_valid), 32'd1);
        check({tag, "_res"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_flg"}, 32'(flg), 32'(exp_flg));
    endtask

    task automatic go_idle();
        bus.in_valid = 1'b0;
        bus.aluop    = ALU_ADD;
        bus.data1    = '0;
        bus.data2    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        go_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov",  32'(bus.out_valid), 32'd0);
        check("rst_res", 32'(bus.result), 32'd0);
        check("rst_flg", 32'(flg), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops, back-to-back
        do_op("add_wrap", ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b10110);
        do_op("sub_ovf",  ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00111);
        do_op("sub_eq",   ALU_SUB, 16'h0005, 16'h0005, 16'h0000, 5'b10010);
        do_op("sra",      ALU_SRA, 16'h8000, 16'h0013, 16'hF000, 5'b00100);
        do_op("sll",      ALU_SLL, 16'h0001, 16'h000F, 16'h8000, 5'b01000);
        do_op("srl_mask", ALU_SRL, 16'h8000, 16'h0010, 16'h8000, 5'b00100);
        do_op("and",      ALU_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00100);
        do_op("or",       ALU_OR,  16'h1200, 16'h0034, 16'h1234, 5'b00100);
        do_op("xor",      ALU_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 5'b10000);
        do_op("op12_add", 4'd12,   16'h0002, 16'h0003, 16'h0005, 5'b01000);
        go_idle();
        @(posedge clk); #1;
        check("ov_drop", 32'(bus.out_valid), 32'd0);

        // MUL 300*300 with a held-off ADD waiting behind it
        bus.in_valid = 1'b1;
        bus.aluop    = ALU_MUL;
        bus.data1    = 16'd300;
        bus.data2    = 16'd300;
        #1;
        check("mul_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.aluop = ALU_ADD;
        bus.data1 = 16'd1;
        bus.data2 = 16'd1;
        check("mul_busy_0", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            check($sformatf("mul_busy_%0d", k), {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check("mul_ov",  32'(bus.out_valid), 32'd1);
        check("mul_res", 32'(bus.result), 32'h5F90);
        check("mul_flg", 32'(flg), 32'(5'b00001));
        check("mul_rdy_after", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("held_ov",  32'(bus.out_valid), 32'd1);
        check("held_res", 32'(bus.result), 32'd2);
        check("held_flg", 32'(flg), 32'(5'b00000));
        go_idle();
        @(posedge clk); #1;

        // Backpressure: result must hold while the consumer stalls
        bus.out_ready = 1'b0;
        do_op("bp_add", ALU_ADD, 16'h1234, 16'h0001, 16'h1235, 5'b00100);
        bus.aluop = ALU_SUB;
        bus.data1 = 16'd9;
        bus.data2 = 16'd4;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("bp_hold_%0d", k),
                  {bus.in_ready, bus.out_valid, bus.result, 9'd0, flg}, {1'b0, 1'b1, 16'h1235, 9'd0, 5'b00100});
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_next_ov",  32'(bus.out_valid), 32'd1);
        check("bp_next_res", 32'(bus.result), 32'd5);
        check("bp_next_flg", 32'(flg), 32'(5'b00110));

        // Reset during a multiply
        bus.aluop = ALU_MUL;
        bus.data1 = 16'd300;
        bus.data2 = 16'd300;
        @(posedge clk); #1;
        go_idle();
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_ov",  32'(bus.out_valid), 32'd0);
        check("mrst_res", 32'(bus.result), 32'd0);
        check("mrst_flg", 32'(flg), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen++;
        end
        check("mrst_no_ov", 32'(ov_seen), 32'd0);
        do_op("post_rst_add", ALU_ADD, 16'd7, 16'd8, 16'd15, 5'b01000);
        go_idle();
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
